// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM state type and lane helper for the MEM-stage load/store path.
package mips_mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {IDLE, WRITE} lsu_state_t;

   // Bit position of the lane's LSB inside a big-endian word.
   function automatic logic [4:0] lane_lsb(input logic [1:0] size, input logic [1:0] offset);
      logic [1:0] lane;
      case (size)
         SIZE_BYTE: lane = 2'd3 - offset;
         SIZE_HALF: lane = 2'd2 - offset;
         default:   lane = 2'd0;
      endcase
      return {lane, 3'b000};
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  offset,
   input  logic [31:0] read_data,
   input  logic [31:0] store_data,
   output logic [31:0] load_result,
   output logic [31:0] merged_word
);

   logic [4:0]  shift;
   logic [31:0] lane_word;
   logic [31:0] mask;

   always_comb begin
      shift     = lane_lsb(size, offset);
      lane_word = read_data >> shift;
      mask      = 32'hFFFF_FFFF;
      load_result = read_data;
      case (size)
         SIZE_BYTE: begin
            mask        = 32'h0000_00FF;
            load_result = is_unsigned ? {24'h0, lane_word[7:0]}
                                      : {{24{lane_word[7]}}, lane_word[7:0]};
         end
         SIZE_HALF: begin
            mask        = 32'h0000_FFFF;
            load_result = is_unsigned ? {16'h0, lane_word[15:0]}
                                      : {{16{lane_word[15]}}, lane_word[15:0]};
         end
         default: begin
            mask        = 32'hFFFF_FFFF;
            load_result = read_data;
         end
      endcase
      merged_word = (read_data & ~(mask << shift)) | ((store_data & mask) << shift);
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: whole-word memory accesses, RMW for sub-word stores,
// sign/zero-extended loads, and fault flagging for misaligned or illegal requests.
module load_store_unit
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 11
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        err,
   output logic [31:0] err_addr,
   output logic [31:0] dm_address,
   output logic [31:0] dm_write_data,
   output logic        dm_mem_read,
   output logic        dm_mem_write,
   input  logic [31:0] dm_read_data
);

   lsu_state_t  state_q, state_d;
   logic        busy_q, load_valid_q, err_q;
   logic [31:0] load_data_q, err_addr_q, pend_addr_q, pend_data_q;

   logic [31:0] word_addr;
   logic [31:0] load_result, merged_word;
   logic        illegal, misaligned;
   logic        start_load, fault;

   always_comb begin
      word_addr = '0;
      word_addr[ADDR_BITS-1:2] = req_addr[ADDR_BITS-1:2];
   end

   assign illegal    = (req_read & req_write) | (req_size == 2'b11);
   assign misaligned = ((req_size == SIZE_HALF) & req_addr[0]) |
                       ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00));

   lsu_lane_align u_lane_align (
      .size        (req_size),
      .is_unsigned (req_unsigned),
      .offset      (req_addr[1:0]),
      .read_data   (dm_read_data),
      .store_data  (req_wdata),
      .load_result (load_result),
      .merged_word (merged_word)
   );

   // Memory enables are gated by reset so a reset edge never commits a write.
   always_comb begin
      state_d       = state_q;
      dm_mem_read   = 1'b0;
      dm_mem_write  = 1'b0;
      dm_address    = word_addr;
      dm_write_data = req_wdata;
      start_load    = 1'b0;
      fault         = 1'b0;
      if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if (req_read | req_write) begin
                  if (illegal | misaligned) begin
                     fault = 1'b1;
                  end else if (req_read) begin
                     dm_mem_read = 1'b1;
                     start_load  = 1'b1;
                  end else if (req_size == SIZE_WORD) begin
                     dm_mem_write = 1'b1;
                  end else begin
                     dm_mem_read = 1'b1;
                     state_d     = WRITE;
                  end
               end
            end
            WRITE: begin
               dm_mem_write  = 1'b1;
               dm_address    = pend_addr_q;
               dm_write_data = pend_data_q;
               state_d       = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         load_valid_q <= 1'b0;
         err_q        <= 1'b0;
         load_data_q  <= '0;
         err_addr_q   <= '0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= (state_d == WRITE);
         load_valid_q <= start_load;
         err_q        <= fault;
         if (start_load) load_data_q <= load_result;
         if (fault) err_addr_q <= req_addr;
         if (state_q == IDLE && state_d == WRITE) begin
            pend_addr_q <= word_addr;
            pend_data_q <= merged_word;
         end
      end
   end

   assign busy       = busy_q;
   assign load_valid = load_valid_q;
   assign load_data  = load_data_q;
   assign err        = err_q;
   assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a big-endian word memory model.
module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_read, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        busy, load_valid, err, dm_mem_read, dm_mem_write;
   logic [31:0] load_data, err_addr, dm_address, dm_write_data, dm_read_data;

   typedef struct packed {
      logic        is_err;
      logic [31:0] value;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [31:0] mem [0:511];

   always #5 clock = ~clock;

   load_store_unit #(.ADDR_BITS(11)) dut (
      .clock         (clock),
      .reset         (reset),
      .req_read      (req_read),
      .req_write     (req_write),
      .req_size      (req_size),
      .req_unsigned  (req_unsigned),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .busy          (busy),
      .load_data     (load_data),
      .load_valid    (load_valid),
      .err           (err),
      .err_addr      (err_addr),
      .dm_address    (dm_address),
      .dm_write_data (dm_write_data),
      .dm_mem_read   (dm_mem_read),
      .dm_mem_write  (dm_mem_write),
      .dm_read_data  (dm_read_data)
   );

   assign dm_read_data = mem[dm_address[10:2]];
   always @(posedge clock) if (dm_mem_write) mem[dm_address[10:2]] <= dm_write_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Monitor: every load_valid/err pulse is matched against the oldest expectation.
   always @(negedge clock) begin
      if (!reset && (load_valid || err)) begin
         check("valid_err_exclusive", {31'h0, load_valid & err}, 32'h0);
         if (sb.size() == 0) begin
            check("unexpected_output", {30'h0, err, load_valid}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_kind", {31'h0, err}, {31'h0, e.is_err});
            check("out_value", err ? err_addr : load_data, e.value);
         end
      end
   end

   // kind: 0 none, 1 load result, 2 error
   task automatic issue(input string name, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int kind, input logic [31:0] exp_val, input int exp_busy);
      int n;
      exp_t e;
      req_read = rd; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      #1;
      if (kind == 2) check({name, "_no_mem_access"}, {30'h0, dm_mem_read, dm_mem_write}, 32'h0);
      if (kind != 0) begin
         e.is_err = (kind == 2);
         e.value  = exp_val;
         sb.push_back(e);
      end
      @(posedge clock); #1;
      if (kind != 0)
         check({name, "_pulse"}, {30'h0, err, load_valid}, (kind == 2) ? 32'h2 : 32'h1);
      n = 0;
      while (busy && n < 5) begin
         n++;
         @(posedge clock); #1;
      end
      check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
      req_read = 1'b0; req_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      mem[4] = 32'h8899AABB;
      reset = 1'b1;
      req_read = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_load_valid", {31'h0, load_valid}, 32'h0);
      check("reset_err", {31'h0, err}, 32'h0);
      check("reset_load_data", load_data, 32'h0);
      check("reset_err_addr", err_addr, 32'h0);
      check("reset_mem_enables", {30'h0, dm_mem_read, dm_mem_write}, 32'h0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Loads against 0x8899AABB @0x10, issued back to back.
      issue("lb_11",  1, 0, 2'b00, 0, 32'h11, 0, 1, 32'hFFFFFF99, 0);
      issue("lbu_11", 1, 0, 2'b00, 1, 32'h11, 0, 1, 32'h00000099, 0);
      issue("lh_12",  1, 0, 2'b01, 0, 32'h12, 0, 1, 32'hFFFFAABB, 0);
      issue("lhu_10", 1, 0, 2'b01, 1, 32'h10, 0, 1, 32'h00008899, 0);
      issue("lbu_10", 1, 0, 2'b00, 1, 32'h10, 0, 1, 32'h00000088, 0);
      issue("lb_13",  1, 0, 2'b00, 0, 32'h13, 0, 1, 32'hFFFFFFBB, 0);
      issue("lw_10",  1, 0, 2'b10, 0, 32'h10, 0, 1, 32'h8899AABB, 0);

      // Reset during the WRITE cycle of a sub-word store discards it.
      req_read = 1'b0; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h13; req_wdata = 32'hCC;
      @(posedge clock); #1;
      check("rst_wr_busy_set", {31'h0, busy}, 32'h1);
      reset = 1'b1;
      @(posedge clock); #1;
      check("rst_wr_busy_clr", {31'h0, busy}, 32'h0);
      check("rst_wr_mem", mem[4], 32'h8899AABB);
      reset = 1'b0; req_write = 1'b0;
      @(posedge clock); #1;
      issue("lw_after_rst", 1, 0, 2'b10, 0, 32'h10, 0, 1, 32'h8899AABB, 0);

      // Stores.
      issue("sb_13", 0, 1, 2'b00, 0, 32'h13, 32'h000000CC, 0, 0, 1);
      check("sb_13_mem", mem[4], 32'h8899AACC);
      issue("lw_after_sb", 1, 0, 2'b10, 0, 32'h10, 0, 1, 32'h8899AACC, 0);
      issue("sh_10", 0, 1, 2'b01, 0, 32'h10, 32'hFFFF1234, 0, 0, 1);
      check("sh_10_mem", mem[4], 32'h1234AACC);
      issue("sw_10", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
      check("sw_10_mem", mem[4], 32'hDEADBEEF);
      issue("lw_after_sw", 1, 0, 2'b10, 0, 32'h10, 0, 1, 32'hDEADBEEF, 0);
      issue("sh_12", 0, 1, 2'b01, 0, 32'h12, 32'h00005566, 0, 0, 1);
      issue("lhu_12", 1, 0, 2'b01, 1, 32'h12, 0, 1, 32'h00005566, 0);
      issue("lh_10",  1, 0, 2'b01, 0, 32'h10, 0, 1, 32'hFFFFDEAD, 0);
      issue("sb_10", 0, 1, 2'b00, 0, 32'h10, 32'h00000011, 0, 0, 1);
      issue("lw_after_sb10", 1, 0, 2'b10, 0, 32'h10, 0, 1, 32'h11AD5566, 0);

      // Faults: misaligned, illegal size, read+write together.
      issue("lw_12_mis", 1, 0, 2'b10, 0, 32'h12, 0, 2, 32'h00000012, 0);
      issue("sh_11_mis", 0, 1, 2'b01, 0, 32'h11, 32'h7777, 2, 32'h00000011, 0);
      issue("size_11",   1, 0, 2'b11, 0, 32'h20, 0, 2, 32'h00000020, 0);
      issue("rd_and_wr", 1, 1, 2'b10, 0, 32'h10, 32'h0BADF00D, 2, 32'h00000010, 0);
      check("fault_mem_unchanged", mem[4], 32'h11AD5566);

      // Address bits above ADDR_BITS are dropped.
      req_read = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'hFFFF_F812;
      #1;
      check("high_addr_dm_address", dm_address, 32'h00000010);
      issue("lw_alias", 1, 0, 2'b10, 0, 32'hFFFF_F810, 0, 1, 32'h11AD5566, 0);

      repeat (2) @(posedge clock);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
